// File: rtl/mesh_input_unit.sv
// Per-port input stage of the 5-port mesh router.
// Buffers single-flit packets in a small FIFO and computes the XY route of
// each flit as it is enqueued. The head flit's one-hot route is presented as
// portRequest and held until a matching grant pops it.
// Port bit order: 0 North, 1 East, 2 South, 3 West, 4 Local.
module mesh_input_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LOCAL_X    = 0,
    parameter int LOCAL_Y    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         dataIn,
    input  logic                          dataInValid,
    output logic                          dataInReady,
    output logic [DATA_WIDTH-1:0]         dataOut,
    output logic [4:0]                    portRequest,
    input  logic [4:0]                    portGrant,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_BITS-1:0] MY_X = ADDR_BITS'(LOCAL_X);
    localparam logic [ADDR_BITS-1:0] MY_Y = ADDR_BITS'(LOCAL_Y);
    localparam logic [CNT_W-1:0]     FULL_COUNT = CNT_W'(FIFO_DEPTH);

    localparam logic [4:0] ROUTE_NORTH = 5'b00001;
    localparam logic [4:0] ROUTE_EAST  = 5'b00010;
    localparam logic [4:0] ROUTE_SOUTH = 5'b00100;
    localparam logic [4:0] ROUTE_WEST  = 5'b01000;
    localparam logic [4:0] ROUTE_LOCAL = 5'b10000;

    // Flit and route storage; no reset needed because outputs are masked when empty.
    logic [DATA_WIDTH-1:0] data_mem_q  [FIFO_DEPTH];
    logic [4:0]            route_mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic [ADDR_BITS-1:0] dest_x;
    logic [ADDR_BITS-1:0] dest_y;
    logic [4:0]           route_in;
    logic                 not_empty;
    logic                 push;
    logic                 pop;

    assign dest_x = dataIn[DATA_WIDTH-1 -: ADDR_BITS];
    assign dest_y = dataIn[DATA_WIDTH-1-ADDR_BITS -: ADDR_BITS];

    // XY routing: resolve X first, then Y, otherwise deliver locally.
    always_comb begin
        route_in = ROUTE_LOCAL;
        if (dest_x > MY_X) begin
            route_in = ROUTE_EAST;
        end else if (dest_x < MY_X) begin
            route_in = ROUTE_WEST;
        end else if (dest_y > MY_Y) begin
            route_in = ROUTE_SOUTH;
        end else if (dest_y < MY_Y) begin
            route_in = ROUTE_NORTH;
        end
    end

    assign not_empty   = (count_q != '0);
    assign dataInReady = (count_q != FULL_COUNT);
    assign fifoCount   = count_q;

    // Head presentation: zero on both outputs while empty.
    assign dataOut     = not_empty ? data_mem_q[rd_ptr_q]  : '0;
    assign portRequest = not_empty ? route_mem_q[rd_ptr_q] : 5'b00000;

    // portRequest is zero when empty, so a stray grant cannot pop anything.
    assign push = dataInValid && dataInReady && !reset;
    assign pop  = |(portGrant & portRequest);

    // Pointer and occupancy next-state; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // State register with synchronous reset discarding all stored flits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write: flit and its precomputed route land at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q]  <= dataIn;
            route_mem_q[wr_ptr_q] <= route_in;
        end
    end

endmodule

// File: tb/tb_mesh_input_unit.sv
// Randomized and directed bench for mesh_input_unit with a queue-based reference model.
module tb_mesh_input_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dataIn;
    logic        dataInValid;
    logic        dataInReady;
    logic [15:0] dataOut;
    logic [4:0]  portRequest;
    logic [4:0]  portGrant;
    logic [2:0]  fifoCount;

    int total = 0;
    int bad   = 0;

    logic [15:0] mq[$];
    bit          model_on = 0;

    mesh_input_unit #(
        .DATA_WIDTH(16),
        .ADDR_BITS (2),
        .FIFO_DEPTH(4),
        .LOCAL_X   (1),
        .LOCAL_Y   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dataIn     (dataIn),
        .dataInValid(dataInValid),
        .dataInReady(dataInReady),
        .dataOut    (dataOut),
        .portRequest(portRequest),
        .portGrant  (portGrant),
        .fifoCount  (fifoCount)
    );

    always #5 clk = ~clk;

    // XY route for a router at (1,1): X decides first, then Y, else Local.
    function automatic logic [4:0] route_of(logic [15:0] f);
        int dx;
        int dy;
        dx = int'(f[15:14]);
        dy = int'(f[13:12]);
        if (dx > 1) return 5'b00010;
        if (dx < 1) return 5'b01000;
        if (dy > 1) return 5'b00100;
        if (dy < 1) return 5'b00001;
        return 5'b10000;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO queue updated from the inputs seen at each edge.
    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (reset) begin
            mq.delete();
            model_on = 1;
        end else if (model_on) begin
            do_pop  = (mq.size() > 0) && (|(portGrant & route_of(mq[0])));
            do_push = dataInValid && (mq.size() < 4);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(dataIn);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_count", 32'(fifoCount), 32'(mq.size()));
            chk("m_ready", 32'(dataInReady), 32'(mq.size() != 4));
            chk("m_data",  32'(dataOut), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            chk("m_req",   32'(portRequest), (mq.size() > 0) ? 32'(route_of(mq[0])) : 32'd0);
        end
    end

    logic [15:0] rd_f   [5] = '{16'h9001, 16'h1002, 16'h6003, 16'h4004, 16'h5005};
    logic [4:0]  rd_exp [5] = '{5'b00010, 5'b01000, 5'b00100, 5'b00001, 5'b10000};
    logic [15:0] full_f [4] = '{16'h0111, 16'hC222, 16'h7333, 16'h5444};

    initial begin
        reset = 1'b1;
        dataIn = '0;
        dataInValid = 1'b0;
        portGrant = '0;

        // Reset held for two edges.
        step();
        step();
        chk("rst_req",   32'(portRequest), 32'h0);
        chk("rst_ready", 32'(dataInReady), 32'h1);
        chk("rst_count", 32'(fifoCount), 32'h0);
        chk("rst_data",  32'(dataOut), 32'h0);
        reset = 1'b0;

        // Route decode: one push per cycle, head granted the cycle after it appears.
        for (int i = 0; i < 5; i++) begin
            dataInValid = 1'b1;
            dataIn = rd_f[i];
            portGrant = (i == 0) ? 5'b00000 : rd_exp[i-1];
            step();
            chk("route_req",  32'(portRequest), 32'(rd_exp[i]));
            chk("route_data", 32'(dataOut), 32'(rd_f[i]));
        end
        dataInValid = 1'b0;
        portGrant = rd_exp[4];
        step();
        portGrant = '0;
        chk("route_empty", 32'(fifoCount), 32'h0);

        // Hold until a matching grant.
        dataInValid = 1'b1;
        dataIn = 16'h8ABC;
        step();
        dataInValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            portGrant = 5'b00001;
            step();
            chk("hold_req",   32'(portRequest), 32'h02);
            chk("hold_data",  32'(dataOut), 32'h8ABC);
            chk("hold_count", 32'(fifoCount), 32'h1);
        end
        portGrant = 5'b00010;
        step();
        portGrant = '0;
        chk("hold_pop", 32'(fifoCount), 32'h0);

        // Fill to capacity and offer one more.
        for (int i = 0; i < 4; i++) begin
            dataInValid = 1'b1;
            dataIn = full_f[i];
            step();
        end
        chk("full_count", 32'(fifoCount), 32'h4);
        chk("full_ready", 32'(dataInReady), 32'h0);
        dataIn = 16'hDEAD;
        step();
        dataInValid = 1'b0;
        chk("full_reject", 32'(fifoCount), 32'h4);
        portGrant = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(dataOut), 32'(full_f[i]));
            step();
        end
        portGrant = '0;
        chk("drain_empty", 32'(fifoCount), 32'h0);

        // Simultaneous push and pop at occupancy two, wrapping the pointers.
        for (int i = 0; i < 2; i++) begin
            dataInValid = 1'b1;
            dataIn = 16'(32'h3A00 + i);
            step();
        end
        portGrant = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            dataIn = 16'($urandom);
            step();
            chk("wrap_count", 32'(fifoCount), 32'h2);
        end
        dataInValid = 1'b0;
        step();
        step();
        portGrant = '0;
        chk("wrap_empty", 32'(fifoCount), 32'h0);

        // Reset mid-operation with a push and a grant pending.
        for (int i = 0; i < 3; i++) begin
            dataInValid = 1'b1;
            dataIn = full_f[i];
            step();
        end
        chk("mid_fill", 32'(fifoCount), 32'h3);
        reset = 1'b1;
        dataIn = 16'hAAAA;
        portGrant = 5'b11111;
        step();
        reset = 1'b0;
        dataInValid = 1'b0;
        portGrant = '0;
        chk("mid_count", 32'(fifoCount), 32'h0);
        chk("mid_req",   32'(portRequest), 32'h0);
        chk("mid_data",  32'(dataOut), 32'h0);
        step();
        chk("mid_nostore", 32'(fifoCount), 32'h0);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            dataInValid = ($urandom_range(0, 2) != 0);
            dataIn = 16'($urandom);
            portGrant = ($urandom_range(0, 3) == 0) ? 5'b11111 : 5'($urandom);
            step();
        end
        reset = 1'b0;
        dataInValid = 1'b0;
        portGrant = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
